// File: rtl/mvm_result_fifo.sv
// Result FIFO behind the MVM NoC AXI-Stream master, drained by the host over a 4-bit Avalon-MM slave.
// Optional threshold interrupt (port irq, register 8) is built when MVM_RESULT_IRQ_EN is defined.
module mvm_result_fifo #(
  parameter int DATAW = 128,
  parameter int IDW   = 4,
  parameter int DESTW = 12,
  parameter int USERW = 75,
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             axis_m_tvalid,
  output logic             axis_m_tready,
  input  logic [DATAW-1:0] axis_m_tdata,
  input  logic             axis_m_tlast,
  input  logic [IDW-1:0]   axis_m_tid,
  input  logic [DESTW-1:0] axis_m_tdest,
  input  logic [USERW-1:0] axis_m_tuser,
  input  logic [3:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata
`ifdef MVM_RESULT_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int AW   = $clog2(DEPTH);
  localparam int ENTW = DATAW + 5;
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  logic [ENTW-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [CNTW-1:0] beats_q, beats_d;
  logic            uf_q, uf_d;
  logic [31:0]     readdata_q, rd_mux;

  logic bus_wr, bus_rd, ctl_wr, flush_cmd, pop_cmd, clr_cmd;
  logic empty, full, push, pop_ok, uf_set;
  logic [ENTW-1:0] head;

  assign bus_wr    = chipselect && write;
  assign bus_rd    = chipselect && read;
  assign ctl_wr    = bus_wr && (address == 4'd6);
  assign flush_cmd = ctl_wr && writedata[1];
  assign pop_cmd   = ctl_wr && writedata[0];
  assign clr_cmd   = ctl_wr && writedata[2];

  assign empty         = (count_q == '0);
  assign full          = (count_q == FULL_CNT);
  assign axis_m_tready = !full && !flush_cmd;
  assign push          = axis_m_tvalid && axis_m_tready;
  // Flush swallows a same-write pop entirely, so it can neither advance nor underflow.
  assign pop_ok        = pop_cmd && !flush_cmd && !empty;
  assign uf_set        = pop_cmd && !flush_cmd && empty;
  assign head          = mem_q[rd_ptr_q];

  logic unused_ok;
  assign unused_ok = ^{axis_m_tid, axis_m_tuser, axis_m_tdest[DESTW-1:4], writedata[31:3]};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    beats_d  = beats_q;
    uf_d     = uf_q;
    if (flush_cmd) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    // Clear beats a same-cycle push or underflow.
    if (clr_cmd) begin
      beats_d = '0;
      uf_d    = 1'b0;
    end else begin
      if (push && beats_q != CNT_MAX) beats_d = beats_q + 1'b1;
      if (uf_set) uf_d = 1'b1;
    end
  end

`ifdef MVM_RESULT_IRQ_EN
  logic [6:0] thr_q, thr_d;
  logic       irq_q;

  always_comb begin
    thr_d = thr_q;
    if (bus_wr && address == 4'd8) thr_d = writedata[6:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thr_q <= 7'd1;
      irq_q <= 1'b0;
    end else begin
      thr_q <= thr_d;
      irq_q <= (7'(count_d) >= thr_d) && (thr_d != '0);
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      4'd0, 4'd1, 4'd2, 4'd3: if (!empty) rd_mux = head[{address[1:0], 5'b0} +: 32];
      4'd4: rd_mux = {17'b0, 7'(count_q), 5'b0, uf_q, full, !empty};
      4'd5: if (!empty) rd_mux = {27'b0, head[ENTW-1], head[DATAW+3:DATAW]};
      4'd7: rd_mux[CNTW-1:0] = beats_q;
`ifdef MVM_RESULT_IRQ_EN
      4'd8: rd_mux = {25'b0, thr_q};
`endif
      default: rd_mux = '0;
    endcase
  end

  // Storage is not reset: pointers/count clearing is what discards buffered data.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {axis_m_tlast, axis_m_tdest[3:0], axis_m_tdata};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beats_q    <= '0;
      uf_q       <= 1'b0;
      readdata_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      beats_q  <= beats_d;
      uf_q     <= uf_d;
      if (bus_rd) readdata_q <= rd_mux;
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_mvm_result_fifo.sv
// Scoreboard bench for mvm_result_fifo: queue-based model, directed scenarios then random traffic.
module tb_mvm_result_fifo;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         axis_m_tvalid = 1'b0;
  logic         axis_m_tready;
  logic [127:0] axis_m_tdata = '0;
  logic         axis_m_tlast = 1'b0;
  logic [3:0]   axis_m_tid = '0;
  logic [11:0]  axis_m_tdest = '0;
  logic [74:0]  axis_m_tuser = '0;
  logic [3:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
`ifdef MVM_RESULT_IRQ_EN
  logic         irq;
`endif

  mvm_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .axis_m_tvalid(axis_m_tvalid), .axis_m_tready(axis_m_tready),
    .axis_m_tdata(axis_m_tdata), .axis_m_tlast(axis_m_tlast),
    .axis_m_tid(axis_m_tid), .axis_m_tdest(axis_m_tdest), .axis_m_tuser(axis_m_tuser),
    .address(address), .chipselect(chipselect), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata)
`ifdef MVM_RESULT_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [127:0] data; logic [3:0] dest; logic last; } beat_t;
  typedef struct { logic [31:0] val; logic [3:0] addr; } exp_t;

  beat_t       fifo_m[$];
  exp_t        exp_q[$];
  int unsigned beats_m = 0;
  bit          uf_m = 0;
  logic [6:0]  thr_m = 7'd1;
  int          compared = 0;
  int          mismatched = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] r;
    r = '0;
    if (a <= 4'd3) begin
      if (fifo_m.size() != 0) r = fifo_m[0].data[32*a +: 32];
    end else if (a == 4'd4) begin
      r = 32'(fifo_m.size()) << 8;
      r[0] = fifo_m.size() != 0;
      r[1] = fifo_m.size() == DEPTH;
      r[2] = uf_m;
    end else if (a == 4'd5) begin
      if (fifo_m.size() != 0) r = {27'b0, fifo_m[0].last, fifo_m[0].dest};
    end else if (a == 4'd7) begin
      r = beats_m;
`ifdef MVM_RESULT_IRQ_EN
    end else if (a == 4'd8) begin
      r = {25'b0, thr_m};
`endif
    end
    return r;
  endfunction

  // One bus/stream cycle: drive, check tready against the model, queue any read expectation, advance the model.
  task automatic step(input bit tv, input logic [127:0] d, input logic [3:0] dst, input bit lst,
                      input bit rd, input bit wr, input logic [3:0] a, input logic [31:0] wd);
    bit fl, pop, clr, acc;
    beat_t b;
    @(posedge clk); #1;
    axis_m_tvalid = tv;
    axis_m_tdata  = d;
    axis_m_tdest  = {8'($urandom), dst};
    axis_m_tlast  = lst;
    axis_m_tid    = 4'($urandom);
    axis_m_tuser  = {11'($urandom), $urandom, $urandom};
    chipselect    = rd || wr;
    read          = rd;
    write         = wr;
    address       = a;
    writedata     = wd;
    fl  = wr && a == 4'd6 && wd[1];
    pop = wr && a == 4'd6 && wd[0] && !fl;
    clr = wr && a == 4'd6 && wd[2];
    acc = tv && (fifo_m.size() < DEPTH) && !fl;
    #1;
    check("tready", 32'(axis_m_tready), 32'((fifo_m.size() < DEPTH) && !fl));
`ifdef MVM_RESULT_IRQ_EN
    check("irq", 32'(irq), 32'((fifo_m.size() >= thr_m) && (thr_m != 0)));
`endif
    if (rd) exp_q.push_back('{model_read(a), a});
    if (fl) fifo_m.delete();
    else if (pop) begin
      if (fifo_m.size() == 0) uf_m = 1;
      else void'(fifo_m.pop_front());
    end
    if (acc) begin
      b.data = d; b.dest = dst; b.last = lst;
      fifo_m.push_back(b);
    end
    if (clr) begin
      beats_m = 0;
      uf_m = 0;
    end else if (acc && beats_m != 65535) beats_m++;
`ifdef MVM_RESULT_IRQ_EN
    if (wr && a == 4'd8) thr_m = wd[6:0];
`endif
  endtask

  task automatic idle();
    step(0, '0, '0, 0, 0, 0, '0, '0);
  endtask
  task automatic rd_reg(input logic [3:0] a);
    step(0, '0, '0, 0, 1, 0, a, '0);
  endtask
  task automatic wr_reg(input logic [3:0] a, input logic [31:0] wd);
    step(0, '0, '0, 0, 0, 1, a, wd);
  endtask
  task automatic push_beat(input logic [127:0] d);
    step(1, d, 4'($urandom), 1'($urandom), 0, 0, '0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    axis_m_tvalid = 0; chipselect = 0; read = 0; write = 0;
    fifo_m.delete(); beats_m = 0; uf_m = 0; thr_m = 7'd1;
    #2;
    check("reset_readdata", readdata, 32'h0);
    check("reset_tready", 32'(axis_m_tready), 32'h1);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // Monitor: a read strobe seen on one falling edge is due on the next; otherwise readdata must hold.
  bit          rd_prev = 0;
  logic [31:0] last_rd = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      rd_prev = 0;
      last_rd = '0;
    end else begin
      if (rd_prev) begin
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL readdata: read completed with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          check($sformatf("reg%0d", e.addr), readdata, e.val);
        end
        last_rd = readdata;
      end else begin
        check("readdata_hold", readdata, last_rd);
      end
      rd_prev = chipselect && read;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    logic [31:0] wd;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single beat: status 0x0101, reg0 0x89ABCDEF, reg5 0x13, reg7 1.
    step(1, 128'h0123456789ABCDEF0123456789ABCDEF, 4'h3, 1, 0, 0, '0, '0);
    rd_reg(4); rd_reg(0); rd_reg(1); rd_reg(2); rd_reg(3); rd_reg(5); rd_reg(7);
    wr_reg(6, 1);

    // Fill to DEPTH, attempt one more, drain in order.
    for (int k = 0; k < DEPTH; k++) push_beat(128'(k));
    push_beat(128'hDEAD);
    rd_reg(4);
    for (int k = 0; k < DEPTH; k++) begin rd_reg(0); wr_reg(6, 1); end
    rd_reg(4);

    // Count 3, push and pop together.
    for (int k = 0; k < 3; k++) push_beat(128'(k + 16));
    step(1, 128'h55, 4'h9, 0, 0, 1, 4'd6, 32'h1);
    rd_reg(4); rd_reg(0);
    wr_reg(6, 1); wr_reg(6, 1); rd_reg(0); rd_reg(5);
    wr_reg(6, 2); rd_reg(4);

    // Underflow sticky, then clear.
    wr_reg(6, 1); rd_reg(4); rd_reg(7);
    wr_reg(6, 4); rd_reg(4); rd_reg(7);

    // Flush at count 5 while tvalid held high.
    for (int k = 0; k < 5; k++) push_beat(128'(k + 32));
    step(1, 128'hF00D, 4'h1, 1, 0, 1, 4'd6, 32'h2);
    step(1, 128'hF00D, 4'h1, 1, 1, 0, 4'd4, '0);
    rd_reg(4); rd_reg(0);

    // Pop and push on an empty FIFO; clear racing a push.
    wr_reg(6, 2);
    step(1, 128'hABC, 4'h7, 0, 0, 1, 4'd6, 32'h1);
    rd_reg(4); rd_reg(5);
    step(1, 128'hABD, 4'h2, 1, 0, 1, 4'd6, 32'h4);
    rd_reg(7); rd_reg(4);

    // Non-control writes and unmapped reads.
    wr_reg(3, 32'hFFFF_FFFF); wr_reg(8, 32'h4);
    rd_reg(6); rd_reg(8); rd_reg(15); rd_reg(4);

`ifdef MVM_RESULT_IRQ_EN
    wr_reg(6, 2); wr_reg(8, 4);
    for (int k = 0; k < 5; k++) push_beat(128'(k));
    wr_reg(6, 1); wr_reg(6, 1); idle();
    wr_reg(8, 0);
    for (int k = 0; k < 3; k++) push_beat(128'(k));
    rd_reg(8);
`endif

    // Reset mid-transfer.
    for (int k = 0; k < 4; k++) push_beat(128'(k + 64));
    idle();
    do_reset();
    rd_reg(4); rd_reg(0); rd_reg(7);

    // Random traffic in two phases: producer-heavy, then consumer-heavy.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40) wd = 32'h1;
      else if (r < 48) wd = 32'h4;
      else if (r < 53) wd = 32'h2;
      else wd = 32'($urandom_range(0, 7));
      r = $urandom_range(0, 99);
      if (r < 35)
        step($urandom_range(0, 99) < (n < 1500 ? 70 : 30), {$urandom, $urandom, $urandom, $urandom},
             4'($urandom), 1'($urandom), 1, 0, 4'($urandom), '0);
      else if (r < 60)
        step($urandom_range(0, 99) < (n < 1500 ? 70 : 30), {$urandom, $urandom, $urandom, $urandom},
             4'($urandom), 1'($urandom), 0, 1, 4'd6, wd);
      else if (r < 64)
        step($urandom_range(0, 99) < 50, {$urandom, $urandom, $urandom, $urandom},
             4'($urandom), 1'($urandom), 0, 1, 4'($urandom), $urandom);
      else
        step($urandom_range(0, 99) < (n < 1500 ? 70 : 30), {$urandom, $urandom, $urandom, $urandom},
             4'($urandom), 1'($urandom), 0, 0, '0, '0);
    end

    repeat (3) idle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
